// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_rdy;
    logic          d_re;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_rdy;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  i_req, i_addr, d_re, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_rdy, d_rdata, d_rdy, m_en, m_we, m_addr, m_wdata,
               stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr, d_re, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_rdy, d_rdata, d_rdy, m_en, m_we, m_addr, m_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hlt,
    output logic           idle,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          win_d_q, win_d_d;   // 1: current transaction belongs to the data port
    logic          wr_q, wr_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_req;
    logic          grant_d;

    assign d_req = bus.d_re | bus.d_we;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;

    // On contention the port that did not win last time gets the slot.
    always_comb begin
        grant_d = d_req;
        if (d_req && bus.i_req)
            grant_d = ~last_d_q;
    end

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == S_IDLE && !hlt && (d_req || bus.i_req))
            last_d_d = grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_d_q <= 1'b1;
        else        last_d_q <= last_d_d;
    end
`else
    always_comb grant_d = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d_d   = win_d_q;
        wr_d      = wr_q;
        m_we_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (!hlt && (d_req || bus.i_req)) begin
                    win_d_d  = grant_d;
                    wr_d     = grant_d & bus.d_we;
                    m_we_d   = grant_d & bus.d_we;
                    m_addr_d = grant_d ? bus.d_addr : bus.i_addr;
                    if (grant_d && bus.d_we)
                        m_wdata_d = bus.d_wdata;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // WAIT is always visited once so the capture lands on the cycle
                // m_rdata is valid, which keeps rdy at LAT+2 cycles after the grant.
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!wr_q) begin
                        if (win_d_q) d_rdata_d = bus.m_rdata;
                        else         i_rdata_d = bus.m_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            win_d_q   <= 1'b0;
            wr_q      <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_d_q   <= win_d_d;
            wr_q      <= wr_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Decoded from state so a reset removes m_en and rdy without waiting for a clock.
    assign bus.m_en      = (state_q == S_ISSUE);
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_rdy     = (state_q == S_RESP) & ~win_d_q;
    assign bus.d_rdy     = (state_q == S_RESP) &  win_d_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.i_req & ~bus.i_rdy;
    assign bus.stall_mem = d_req & ~bus.d_rdy;
    assign idle          = (state_q == S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected read data is queued at request time
// and popped when the matching rdy pulse appears.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hlt = 1'b0;
    logic idle;
    int   vecs = 0;
    int   errs = 0;
    logic [15:0] exp_i[$];
    logic [15:0] exp_d[$];
    logic [15:0] rd_pipe [LAT];

    mem_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_arbiter #(.AW(16), .DW(16), .LAT(LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hlt  (hlt),
        .idle (idle),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hA5A5;
            16'h0020: return 16'h5A5A;
            16'h0030: return 16'hBEEF;
            16'h0040: return 16'hC0DE;
            default:  return a ^ 16'h5555;
        endcase
    endfunction

    // Memory model: data is valid exactly LAT cycles after the m_en cycle, junk otherwise.
    always @(posedge clk) begin
        rd_pipe[0] <= (bus.m_en && !bus.m_we) ? mem_val(bus.m_addr) : 16'hDEAD;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.m_rdata = rd_pipe[LAT-1];

    task automatic test_reset;
        rst_n = 1'b0; bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        bus.d_re = 1'b1; bus.d_addr = 16'h0040;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vecs++; if (bus.m_en !== 1'b0) begin errs++; $display("FAIL reset_m_en c%0d: got %b want 0", c, bus.m_en); end
            vecs++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle c%0d: got %b want 1", c, idle); end
        end
        vecs++;
        if ({bus.m_we, bus.i_rdy, bus.d_rdy} !== 3'b000) begin
            errs++; $display("FAIL reset_ctl: got %b want 000", {bus.m_we, bus.i_rdy, bus.d_rdy});
        end
        vecs++;
        if ({bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            errs++; $display("FAIL reset_data: got %h want 0", {bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata});
        end
        bus.i_req = 1'b0; bus.d_re = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch;
        logic got = 1'b0;
        logic [15:0] e;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        exp_i.push_back(16'hA5A5);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vecs++; if (bus.m_en !== (c == 1)) begin errs++; $display("FAIL fetch_m_en c%0d: got %b want %b", c, bus.m_en, c == 1); end
            if (c == 1) begin
                vecs++; if (bus.m_addr !== 16'h0010) begin errs++; $display("FAIL fetch_m_addr: got %h want 0010", bus.m_addr); end
            end
            if (c <= 4) begin
                vecs++; if (bus.stall_if !== (c < 4)) begin errs++; $display("FAIL fetch_stall_if c%0d: got %b want %b", c, bus.stall_if, c < 4); end
            end
            vecs++; if (bus.i_rdy !== (c == 4)) begin errs++; $display("FAIL fetch_i_rdy c%0d: got %b want %b", c, bus.i_rdy, c == 4); end
            if (bus.i_rdy === 1'b1 && exp_i.size() > 0) begin
                e = exp_i.pop_front();
                vecs++; if (bus.i_rdata !== e) begin errs++; $display("FAIL fetch_i_rdata: got %h want %h", bus.i_rdata, e); end
                got = 1'b1;
            end
            @(posedge clk); #1;
            if (got) bus.i_req = 1'b0;
        end
    endtask

    task automatic test_priority;
        logic first_d;
        logic isd;
        logic [15:0] e;
`ifdef MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        bus.i_req = 1'b1; bus.i_addr = 16'h0020;
        bus.d_we = 1'b1; bus.d_addr = 16'h8000; bus.d_wdata = 16'h1234;
        exp_i.push_back(16'h5A5A);
        exp_d.push_back(16'h0000);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            vecs++; if (bus.m_en !== (c == 1 || c == 6)) begin errs++; $display("FAIL prio_m_en c%0d: got %b", c, bus.m_en); end
            if (c == 1 || c == 6) begin
                isd = ((c == 1) == first_d);
                vecs++; if (bus.m_we !== isd) begin errs++; $display("FAIL prio_m_we c%0d: got %b want %b", c, bus.m_we, isd); end
                vecs++; if (bus.m_addr !== (isd ? 16'h8000 : 16'h0020)) begin errs++; $display("FAIL prio_m_addr c%0d: got %h", c, bus.m_addr); end
                if (isd) begin
                    vecs++; if (bus.m_wdata !== 16'h1234) begin errs++; $display("FAIL prio_m_wdata: got %h want 1234", bus.m_wdata); end
                end
            end else begin
                vecs++; if (bus.m_we !== 1'b0) begin errs++; $display("FAIL prio_m_we_idle c%0d: got %b want 0", c, bus.m_we); end
            end
            vecs++; if (bus.d_rdy !== (first_d ? c == 4 : c == 9)) begin errs++; $display("FAIL prio_d_rdy c%0d: got %b", c, bus.d_rdy); end
            vecs++; if (bus.i_rdy !== (first_d ? c == 9 : c == 4)) begin errs++; $display("FAIL prio_i_rdy c%0d: got %b", c, bus.i_rdy); end
            if (bus.d_rdy === 1'b1 && exp_d.size() > 0) begin
                e = exp_d.pop_front();
                vecs++; if (bus.d_rdata !== e) begin errs++; $display("FAIL prio_d_rdata_hold: got %h want %h", bus.d_rdata, e); end
            end
            if (bus.i_rdy === 1'b1 && exp_i.size() > 0) begin
                e = exp_i.pop_front();
                vecs++; if (bus.i_rdata !== e) begin errs++; $display("FAIL prio_i_rdata: got %h want %h", bus.i_rdata, e); end
            end
            isd = bus.d_rdy; first_d = first_d;
            @(posedge clk); #1;
            if (isd === 1'b1) bus.d_we = 1'b0;
            if (bus.i_rdy === 1'b0 && c == (first_d ? 9 : 4)) bus.i_req = 1'b0;
        end
        bus.i_req = 1'b0; bus.d_we = 1'b0;
    endtask

    task automatic test_hlt;
        logic got = 1'b0;
        logic [15:0] e;
        bus.d_re = 1'b1; bus.d_addr = 16'h0030;
        exp_d.push_back(16'hBEEF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vecs++; if (bus.m_en !== (c == 1)) begin errs++; $display("FAIL hlt_m_en c%0d: got %b want %b", c, bus.m_en, c == 1); end
            vecs++; if (idle !== (c == 0 || c >= 5)) begin errs++; $display("FAIL hlt_idle c%0d: got %b", c, idle); end
            vecs++; if (bus.d_rdy !== (c == 4)) begin errs++; $display("FAIL hlt_d_rdy c%0d: got %b want %b", c, bus.d_rdy, c == 4); end
            vecs++; if (bus.i_rdy !== 1'b0) begin errs++; $display("FAIL hlt_i_rdy c%0d: got %b want 0", c, bus.i_rdy); end
            if (c <= 4) begin
                vecs++; if (bus.stall_mem !== (c < 4)) begin errs++; $display("FAIL hlt_stall_mem c%0d: got %b want %b", c, bus.stall_mem, c < 4); end
            end
            if (bus.d_rdy === 1'b1 && exp_d.size() > 0) begin
                e = exp_d.pop_front();
                vecs++; if (bus.d_rdata !== e) begin errs++; $display("FAIL hlt_d_rdata: got %h want %h", bus.d_rdata, e); end
                got = 1'b1;
            end
            @(posedge clk); #1;
            if (c == 1) begin hlt = 1'b1; bus.i_req = 1'b1; bus.i_addr = 16'h0050; end
            if (got) bus.d_re = 1'b0;
        end
        bus.i_req = 1'b0; hlt = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic got = 1'b0;
        logic [15:0] e;
        bus.d_re = 1'b1; bus.d_addr = 16'h0040;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vecs++; if (bus.m_en !== 1'b1) begin errs++; $display("FAIL rmid_issue: got %b want 1", bus.m_en); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vecs++; if ({bus.m_en, bus.d_rdy, idle} !== 3'b001) begin errs++; $display("FAIL rmid_in_reset c%0d: got %b want 001", c, {bus.m_en, bus.d_rdy, idle}); end
        end
        vecs++; if (bus.m_addr !== 16'h0) begin errs++; $display("FAIL rmid_m_addr: got %h want 0000", bus.m_addr); end
        rst_n = 1'b1;
        exp_d.push_back(16'hC0DE);
        for (int n = 1; n < 8; n++) begin
            @(posedge clk); #1;
            if (got) bus.d_re = 1'b0;
            @(negedge clk);
            vecs++; if (bus.m_en !== (n == 1)) begin errs++; $display("FAIL rmid_m_en n%0d: got %b want %b", n, bus.m_en, n == 1); end
            vecs++; if (bus.d_rdy !== (n == LAT + 2)) begin errs++; $display("FAIL rmid_d_rdy n%0d: got %b want %b", n, bus.d_rdy, n == LAT + 2); end
            if (bus.d_rdy === 1'b1 && exp_d.size() > 0) begin
                e = exp_d.pop_front();
                vecs++; if (bus.d_rdata !== e) begin errs++; $display("FAIL rmid_d_rdata: got %h want %h", bus.d_rdata, e); end
                got = 1'b1;
            end
        end
        bus.d_re = 1'b0;
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_re = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        test_reset();
        test_fetch();
        test_priority();
        test_hlt();
        test_reset_mid();
        vecs++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            errs++; $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", exp_i.size(), exp_d.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
